// File: rtl/instr_ctrl_fsm_pkg.sv
// Shared opcode constants, state/class encodings and decode payload for the
// multicycle instruction control sequencer.
package instr_ctrl_fsm_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NIB_W  = 4;

  localparam logic [NIB_W-1:0] OP_RTYPE = 4'h0;
  localparam logic [NIB_W-1:0] OP_ANDI  = 4'h1;
  localparam logic [NIB_W-1:0] OP_ORI   = 4'h2;
  localparam logic [NIB_W-1:0] OP_XORI  = 4'h3;
  localparam logic [NIB_W-1:0] OP_MEM   = 4'h4;
  localparam logic [NIB_W-1:0] OP_ADDI  = 4'h5;
  localparam logic [NIB_W-1:0] OP_SUBI  = 4'h9;
  localparam logic [NIB_W-1:0] OP_CMPI  = 4'hB;
  localparam logic [NIB_W-1:0] OP_MOVI  = 4'hD;

  localparam logic [NIB_W-1:0] EXT_LOAD = 4'h0;
  localparam logic [NIB_W-1:0] EXT_STOR = 4'h4;

  // Compare only updates flags, in both register and immediate form
  localparam logic [NIB_W-1:0] ALU_CMP  = 4'hB;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU_REG,
    CLS_ALU_IMM,
    CLS_LOAD,
    CLS_STOR,
    CLS_ILLEGAL
  } instr_class_e;

  typedef struct packed {
    instr_class_e     cls;
    logic [NIB_W-1:0] alu_op;
    logic             use_imm;
    logic             writes_rf;
  } decode_t;

  function automatic logic is_alu_imm_op(input logic [NIB_W-1:0] op);
    case (op)
      OP_ANDI, OP_ORI, OP_XORI, OP_ADDI, OP_SUBI, OP_CMPI, OP_MOVI: return 1'b1;
      default:                                                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_ctrl_fsm_instr_class_decode.sv
// Combinational instruction classifier: opcode/ext nibbles to class, ALU
// function, immediate select and register-file write intent.
module instr_class_decode
  import instr_ctrl_fsm_pkg::*;
(
  input  logic [NIB_W-1:0] opcode_i,
  input  logic [NIB_W-1:0] ext_i,
  output decode_t          dec_o
);

  always_comb begin
    dec_o.cls       = CLS_ILLEGAL;
    dec_o.alu_op    = '0;
    dec_o.use_imm   = 1'b0;
    dec_o.writes_rf = 1'b0;
    if (opcode_i == OP_RTYPE) begin
      dec_o.cls       = CLS_ALU_REG;
      dec_o.alu_op    = ext_i;
      dec_o.writes_rf = (ext_i != ALU_CMP);
    end else if (is_alu_imm_op(opcode_i)) begin
      dec_o.cls       = CLS_ALU_IMM;
      dec_o.alu_op    = opcode_i;
      dec_o.use_imm   = 1'b1;
      dec_o.writes_rf = (opcode_i != ALU_CMP);
    end else if (opcode_i == OP_MEM && ext_i == EXT_LOAD) begin
      dec_o.cls       = CLS_LOAD;
      dec_o.writes_rf = 1'b1;
    end else if (opcode_i == OP_MEM && ext_i == EXT_STOR) begin
      dec_o.cls       = CLS_STOR;
    end
  end

endmodule

// File: rtl/instr_ctrl_fsm.sv
// Multicycle fetch/decode/execute sequencer for the 16-bit datapath with
// memory request timeout and illegal-opcode handling.
module instr_ctrl_fsm
  import instr_ctrl_fsm_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT  = 16,
  parameter bit          ILLEGAL_HALT = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instr_in,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic              addr_sel,
  output logic [NIB_W-1:0]  imm_upper,
  output logic [NIB_W-1:0]  imm_lower,
  output logic              use_imm,
  output logic [NIB_W-1:0]  alu_op,
  output logic [NIB_W-1:0]  rdest,
  output logic [NIB_W-1:0]  rsrc,
  output logic              rf_we,
  output logic              wb_sel,
  output logic              flags_we,
  output logic              pc_inc,
  output logic              bus_err,
  output logic              illegal,
  output logic              halted
);

  localparam int unsigned CNT_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit          TMO_EN = (MEM_TIMEOUT != 0);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  ir_q, ir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tmo_q, tmo_d;
  logic               tmo_hit;
  logic               is_alu;
  decode_t            dec;

  instr_class_decode u_decode (
    .opcode_i (ir_q[15:12]),
    .ext_i    (ir_q[7:4]),
    .dec_o    (dec)
  );

  assign imm_upper = ir_q[7:4];
  assign imm_lower = ir_q[3:0];
  assign rdest     = ir_q[11:8];
  assign rsrc      = ir_q[3:0];
  assign alu_op    = dec.alu_op;
  assign use_imm   = dec.use_imm;

  assign is_alu  = (dec.cls == CLS_ALU_REG) || (dec.cls == CLS_ALU_IMM);
  // Last allowed wait cycle; a ready in this cycle still completes normally
  assign tmo_hit = TMO_EN && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    cnt_d    = cnt_q;
    tmo_d    = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    flags_we = 1'b0;
    pc_inc   = 1'b0;
    bus_err  = 1'b0;
    illegal  = 1'b0;
    halted   = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;

      ST_FETCH: begin
        if (tmo_q) begin
          bus_err = 1'b1;
          state_d = ST_HALT;
        end else begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_d    = instr_in;
            state_d = ST_DECODE;
          end else if (tmo_hit) begin
            tmo_d = 1'b1;
          end else if (TMO_EN) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_DECODE: begin
        case (dec.cls)
          CLS_ALU_REG, CLS_ALU_IMM: state_d = ST_EXEC;
          CLS_LOAD, CLS_STOR:       state_d = ST_MEM;
          default: begin
            illegal = 1'b1;
            state_d = ILLEGAL_HALT ? ST_HALT : ST_EXEC;
          end
        endcase
      end

      // Illegal words reaching here retire as a NOP: only the PC advances
      ST_EXEC: begin
        pc_inc = 1'b1;
        if (is_alu) begin
          flags_we = 1'b1;
          rf_we    = dec.writes_rf;
        end
        state_d = ST_FETCH;
      end

      ST_MEM: begin
        addr_sel = 1'b1;
        if (tmo_q) begin
          bus_err = 1'b1;
          pc_inc  = 1'b1;
          state_d = ST_FETCH;
        end else begin
          mem_req = 1'b1;
          mem_we  = (dec.cls == CLS_STOR);
          if (mem_ready) begin
            rf_we   = (dec.cls == CLS_LOAD);
            wb_sel  = (dec.cls == CLS_LOAD);
            pc_inc  = 1'b1;
            state_d = ST_FETCH;
          end else if (tmo_hit) begin
            tmo_d = 1'b1;
          end else if (TMO_EN) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_HALT: halted = 1'b1;

      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

endmodule
